// File: rtl/bias2_delta_gen.sv
// bias2_delta_gen
// Computes the output-layer bias deltas deltab2_n = -(err_n * lr) in Q8.8
// for the five-entry bias2 bank, then drives the bank's update port for one
// cycle so the bank adds them. A single shared multiplier processes one entry
// per clock, so a job takes seven busy cycles: five CALC, one COMMIT, one DONE.
//
// Ports
//   clk            rising-edge clock for all state
//   rst_n          asynchronous active-low reset
//   start          job request, sampled only while idle
//   err_1..err_5   signed Q8.8 output-layer errors (latched on the accepting edge)
//   lr             signed Q8.8 learning rate (latched on the accepting edge)
//   step_in        training step tag (latched on the accepting edge)
//   deltab2_1..5   signed Q8.8 deltas to the bank, updated only on entry to COMMIT
//   ctrl           bank command, 4'b0001 during COMMIT, 4'b0000 otherwise
//   step           step tag seen by the bank, non-zero only during COMMIT
//   busy           high whenever the FSM is not idle
//   done           one-cycle pulse in the cycle after COMMIT

module bias2_delta_gen #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] err_1,
    input  logic [DW-1:0] err_2,
    input  logic [DW-1:0] err_3,
    input  logic [DW-1:0] err_4,
    input  logic [DW-1:0] err_5,
    input  logic [DW-1:0] lr,
    input  logic [3:0]    step_in,
    output logic [DW-1:0] deltab2_1,
    output logic [DW-1:0] deltab2_2,
    output logic [DW-1:0] deltab2_3,
    output logic [DW-1:0] deltab2_4,
    output logic [DW-1:0] deltab2_5,
    output logic [3:0]    ctrl,
    output logic [3:0]    step,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int PW = 2 * DW;

    // Clamp limits for the negated value, expressed at the widened width.
    localparam logic signed [PW:0] D_MAX = $signed({{(DW + 2){1'b0}}, {(DW - 1){1'b1}}});
    localparam logic signed [PW:0] D_MIN = $signed({{(DW + 2){1'b1}}, {(DW - 1){1'b0}}});

    state_t        state;
    logic [2:0]    idx;
    logic [DW-1:0] err_q    [5];
    logic [DW-1:0] lr_q;
    logic [3:0]    step_q;
    logic [DW-1:0] shadow   [5];
    logic [DW-1:0] delta_q  [5];

    logic [DW-1:0]        err_sel;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_shr;
    logic signed [PW:0]   d_full;
    logic [DW-1:0]        d_sat;

    // Select the entry the shared multiplier works on this cycle.
    always_comb begin
        err_sel = '0;
        case (idx)
            3'd0:    err_sel = err_q[0];
            3'd1:    err_sel = err_q[1];
            3'd2:    err_sel = err_q[2];
            3'd3:    err_sel = err_q[3];
            3'd4:    err_sel = err_q[4];
            default: err_sel = '0;
        endcase
    end

    // Full-precision product, arithmetic shift back to Q8.8 (floors toward
    // -inf), then negate one bit wider so that negating the most negative
    // shifted value cannot overflow before the clamp.
    assign prod     = $signed(err_sel) * $signed(lr_q);
    assign prod_shr = prod >>> FRAC;
    assign d_full   = -$signed({prod_shr[PW-1], prod_shr});

    always_comb begin
        d_sat = d_full[DW-1:0];
        if (d_full > D_MAX) begin
            d_sat = {1'b0, {(DW - 1){1'b1}}};
        end else if (d_full < D_MIN) begin
            d_sat = {1'b1, {(DW - 1){1'b0}}};
        end
    end

    // Control FSM. The last CALC edge forwards the freshly computed fifth
    // delta straight to the output register, because shadow[4] is only being
    // written on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            lr_q   <= '0;
            step_q <= '0;
            ctrl   <= '0;
            step   <= '0;
            done   <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                err_q[i]   <= '0;
                shadow[i]  <= '0;
                delta_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    ctrl <= '0;
                    step <= '0;
                    done <= 1'b0;
                    if (start) begin
                        err_q[0] <= err_1;
                        err_q[1] <= err_2;
                        err_q[2] <= err_3;
                        err_q[3] <= err_4;
                        err_q[4] <= err_5;
                        lr_q     <= lr;
                        step_q   <= step_in;
                        idx      <= '0;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    case (idx)
                        3'd0:    shadow[0] <= d_sat;
                        3'd1:    shadow[1] <= d_sat;
                        3'd2:    shadow[2] <= d_sat;
                        3'd3:    shadow[3] <= d_sat;
                        default: shadow[4] <= d_sat;
                    endcase
                    if (idx == 3'd4) begin
                        delta_q[0] <= shadow[0];
                        delta_q[1] <= shadow[1];
                        delta_q[2] <= shadow[2];
                        delta_q[3] <= shadow[3];
                        delta_q[4] <= d_sat;
                        ctrl       <= 4'b0001;
                        step       <= step_q;
                        idx        <= '0;
                        state      <= S_COMMIT;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_COMMIT: begin
                    ctrl  <= '0;
                    step  <= '0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ctrl  <= '0;
                    step  <= '0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign deltab2_1 = delta_q[0];
    assign deltab2_2 = delta_q[1];
    assign deltab2_3 = delta_q[2];
    assign deltab2_4 = delta_q[3];
    assign deltab2_5 = delta_q[4];

endmodule
